i2c_target_regs: RTL
====================

// Module: i2c_target_regs
// PURPOSE
// I2C target (responder) with an 8-bit register-pointer interface; the counterpart of our I2C
// master that configures the TFP410. Lets the board be configured and read back over I2C
// (lag results, RES_CONFIG override) from an external host. Sits in the control_clock domain.
// The regfile is outside this block. Open-drain SDA only; SCL is input-only, no clock stretching.
// PARAMETERS
// I2C_ADDR    7'h2A  7-bit target address this block responds to
// FILTER_LEN  3      consecutive equal samples needed before a filtered SCL/SDA level changes
// PORTS
// clock      in   1  system clock; must be >= 20x SCL frequency
// reset      in   1  asynchronous, active-low
// scl_in     in   1  raw SCL pad level (asynchronous)
// sda_in     in   1  raw SDA pad level (asynchronous)
// sda_oe     out  1  1 = pull SDA low; 0 = release (pad is open-drain)
// reg_addr   out  8  register pointer presented with reg_wr/reg_rd
// reg_wdata  out  8  write data; valid while reg_wr=1
// reg_wr     out  1  one-cycle write strobe
// reg_rd     out  1  one-cycle read request; reg_rdata must be valid on the next clock
// reg_rdata  in   8  read data, sampled 1 cycle after reg_rd
// busy       out  1  1 from address match until STOP/repeated START/NACK-end
// BEHAVIOUR
// - Input path: 2-flop synchroniser per line, then glitch filter (FILTER_LEN equal samples);
//   all edge detection uses the filtered levels. Input-to-decision latency = 2+FILTER_LEN clocks.
// - START = SDA fall while SCL high; STOP = SDA rise while SCL high; both legal in any state.
// - Bits are sampled on the filtered SCL rise, MSB first; sda_oe changes only on filtered SCL fall.
// - FSM: IDLE -> DEV_ADDR (8 bits) -> DEV_ACK -> {REG_PTR -> PTR_ACK -> WR_DATA <-> WR_ACK}
//   or {RD_DATA <-> RD_ACK}; WAIT_STOP for a mismatch or NACK.
// - DEV_ADDR: on address mismatch, sda_oe stays 0 and the FSM goes to WAIT_STOP (ignores all
//   bits until STOP/START). On a match, drive ACK (sda_oe=1) from the SCL fall after bit 8 to the
//   SCL fall after bit 9. busy=1.
// - Write (R/W=0): the first data byte loads the pointer (ACKed). Each further byte is ACKed;
//   reg_wr pulses once, with reg_addr=pointer and reg_wdata=byte, on the clock after the 8th-bit
//   SCL rise. The pointer then increments, wrapping 8'hFF -> 8'h00.
// - Read (R/W=1): reg_rd pulses with reg_addr=pointer on the clock after the 9th (ACK) SCL rise
//   of the address byte or of the previous read byte. reg_rdata is latched into the shift register
//   one clock later. The pointer then increments with wrap. On each SCL fall of the 8 data bits,
//   sda_oe = ~bit. Release SDA at the fall after bit 8. At the ACK rise, master ACK (SDA=0) ->
//   next byte; master NACK -> WAIT_STOP, no further reg_rd.
// - Repeated START in any state: release SDA, go to DEV_ADDR, keep the pointer (combined
//   write-pointer/read). STOP in any state: sda_oe=0, busy=0, go to IDLE; the pointer is retained.
// - Reset (async, any time): sda_oe=0, reg_wr=0, reg_rd=0, reg_addr=0, reg_wdata=0, busy=0,
//   pointer=0, FSM=IDLE, filters/synchronisers preset to 1 (bus idle).
// - Bus lines are treated as high after reset, so no false START is taken from the preset.
// - reg_wr and reg_rd are never asserted in the same cycle; each fires at most once per byte.
// TESTING
// 1 START, 0x54(W), 0x10, 0xA5, 0x5A, STOP -> 4 ACKs; reg_wr @0x10=A5, then @0x11=5A.
// 2 START, 0x54, 0xFF, RSTART, 0x55(R), rdata=addr^0xC3, ACK, NACK, STOP -> reads 0x3C
//   then 0xC3 (0xFF then 0x00 wrap); reg_rd exactly twice; sda_oe=0 after the NACK.
// 3 START, 0x56(W), 0x10, 0x77, STOP -> sda_oe never 1; reg_wr never pulses; busy stays 0.
// 4 SDA glitch low for FILTER_LEN-1 clocks while SCL high in IDLE -> no START; the next valid
//   transaction behaves exactly as in 1.
// 5 reset asserted mid-read while driving a 0 bit -> sda_oe=0 same cycle (async);
//   after release, FSM is IDLE, pointer=0.
// 6 STOP in mid-byte of a write (after 4 bits) -> no reg_wr; busy=0; the next write works.

Source files
------------

// File: rtl/i2c_target_regs.sv
// I2C target with an 8-bit register pointer: filtered SCL/SDA inputs, open-drain SDA output,
// and one-cycle reg_wr/reg_rd strobes towards an external register file.
module i2c_target_regs #(
  parameter logic [6:0] I2C_ADDR   = 7'h2A,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_wr,
  output logic       reg_rd,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_PTR, PTR_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t state, next_state;

  // Index 0 is SCL, index 1 is SDA; everything presets high so reset looks like an idle bus.
  logic [1:0]    sync1, sync2, filt, filt_prev;
  logic [CW-1:0] flt_cnt [2];

  logic [7:0] shift, pointer, byte_in;
  logic [3:0] bit_cnt;
  logic       ack_seen, rw, rd_d, last_bit;
  logic       scl_rise, scl_fall, start_cond, stop_cond;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1      <= 2'b11;
      sync2      <= 2'b11;
      filt       <= 2'b11;
      filt_prev  <= 2'b11;
      flt_cnt[0] <= '0;
      flt_cnt[1] <= '0;
    end else begin
      sync1     <= {sda_in, scl_in};
      sync2     <= sync1;
      filt_prev <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          flt_cnt[i] <= '0;
        end else if (flt_cnt[i] == CW'(FILTER_LEN - 1)) begin
          filt[i]    <= sync2[i];
          flt_cnt[i] <= '0;
        end else begin
          flt_cnt[i] <= flt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign scl_rise   = filt[0] & ~filt_prev[0];
  assign scl_fall   = ~filt[0] & filt_prev[0];
  assign start_cond = filt[0] & filt_prev[0] & filt_prev[1] & ~filt[1];
  assign stop_cond  = filt[0] & filt_prev[0] & ~filt_prev[1] & filt[1];
  assign byte_in    = {shift[6:0], filt[1]};
  assign last_bit   = (bit_cnt == 4'd7);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (stop_cond) begin
      next_state = IDLE;
    end else if (start_cond) begin
      next_state = DEV_ADDR;
    end else begin
      case (state)
        DEV_ADDR:
          if (scl_rise && last_bit)
            next_state = (byte_in[7:1] == I2C_ADDR) ? DEV_ACK : WAIT_STOP;
        DEV_ACK:
          if (scl_fall && ack_seen) next_state = rw ? RD_DATA : REG_PTR;
        REG_PTR:
          if (scl_rise && last_bit) next_state = PTR_ACK;
        PTR_ACK, WR_ACK:
          if (scl_fall && ack_seen) next_state = WR_DATA;
        WR_DATA:
          if (scl_rise && last_bit) next_state = WR_ACK;
        RD_DATA:
          if (scl_fall && bit_cnt == 4'd8) next_state = RD_ACK;
        RD_ACK:
          if (scl_rise && filt[1])       next_state = WAIT_STOP;
          else if (scl_fall && ack_seen) next_state = RD_DATA;
        default: next_state = state;
      endcase
    end
  end

  // ack_seen marks that the 9th SCL rise has happened, so the next fall ends the ACK slot.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sda_oe    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      pointer   <= 8'h00;
      shift     <= 8'h00;
      bit_cnt   <= 4'd0;
      ack_seen  <= 1'b0;
      rw        <= 1'b0;
      rd_d      <= 1'b0;
    end else begin
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;
      rd_d   <= reg_rd;
      if (rd_d) shift <= reg_rdata;
      if (start_cond || stop_cond) begin
        sda_oe   <= 1'b0;
        bit_cnt  <= 4'd0;
        ack_seen <= 1'b0;
      end else begin
        case (state)
          DEV_ADDR, REG_PTR, WR_DATA:
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (last_bit) begin
                bit_cnt  <= 4'd0;
                ack_seen <= 1'b0;
                if (state == DEV_ADDR) begin
                  rw <= filt[1];
                end else if (state == REG_PTR) begin
                  pointer <= byte_in;
                end else begin
                  reg_wr    <= 1'b1;
                  reg_addr  <= pointer;
                  reg_wdata <= byte_in;
                  pointer   <= pointer + 8'd1;
                end
              end
            end
          DEV_ACK, PTR_ACK, WR_ACK:
            if (scl_rise) begin
              ack_seen <= 1'b1;
              if (state == DEV_ACK && rw) begin
                reg_rd   <= 1'b1;
                reg_addr <= pointer;
                pointer  <= pointer + 8'd1;
              end
            end else if (scl_fall) begin
              if (!ack_seen) begin
                sda_oe <= 1'b1;
              end else begin
                bit_cnt <= 4'd0;
                sda_oe  <= (state == DEV_ACK && rw) ? ~shift[7] : 1'b0;
              end
            end
          RD_DATA:
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe   <= 1'b0;
                ack_seen <= 1'b0;
                bit_cnt  <= 4'd0;
              end else begin
                shift  <= {shift[6:0], 1'b0};
                sda_oe <= ~shift[6];
              end
            end
          RD_ACK:
            if (scl_rise) begin
              ack_seen <= 1'b1;
              if (!filt[1]) begin
                reg_rd   <= 1'b1;
                reg_addr <= pointer;
                pointer  <= pointer + 8'd1;
              end
            end else if (scl_fall && ack_seen) begin
              sda_oe  <= ~shift[7];
              bit_cnt <= 4'd0;
            end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state == DEV_ACK) || (state == REG_PTR) || (state == PTR_ACK) ||
                (state == WR_DATA) || (state == WR_ACK)  || (state == RD_DATA) ||
                (state == RD_ACK);

endmodule
